// File: rtl/multi_timer_regs_if.sv
// Register bus and interrupt bundle between the AXI4-Lite front end, the
// timer bank and the interrupt controller.
interface multi_timer_regs_if #(
   parameter int AW  = 8,
   parameter int DW  = 32,
   parameter int NCH = 4
);
   logic [AW-1:0]  wr_addr;
   logic [DW-1:0]  wr_data;
   logic           wr_en;
   logic           wr_ready;
   logic [AW-1:0]  rd_addr;
   logic           rd_en;
   logic [DW-1:0]  rd_data;
   logic           rd_valid;
   logic           irq;
   logic [NCH-1:0] irq_vec;

   modport master (
      output wr_addr, wr_data, wr_en, rd_addr, rd_en,
      input  wr_ready, rd_data, rd_valid, irq, irq_vec
   );

   modport slave (
      input  wr_addr, wr_data, wr_en, rd_addr, rd_en,
      output wr_ready, rd_data, rd_valid, irq, irq_vec
   );
endinterface

// File: rtl/multi_timer_regs.sv
// NCH independent 32-bit down-counting timers behind one register map.
// Define TIMER_PRESCALER_EN to build the shared tick prescaler; otherwise the timers tick every cycle.
module multi_timer_regs #(
   parameter int NCH = 4,
   parameter int AW  = 8,
   parameter int DW  = 32
) (
   input logic               clk,
   input logic               rstn,
   multi_timer_regs_if.slave bus
);
   localparam int CW = AW - 4;
   localparam logic [AW-1:0] A_STAT = AW'(32'hF0);
   localparam logic [AW-1:0] A_IEN  = AW'(32'hF4);
   localparam logic [AW-1:0] A_PRE  = AW'(32'hF8);
   localparam logic [DW-1:0] UNMAPPED = 32'hDEAD_BEEF;

   logic [NCH-1:0] en_q, en_d, per_q, per_d, stat_q, stat_d, ien_q, ien_d, fire;
   logic [DW-1:0]  load_q [NCH];
   logic [DW-1:0]  load_d [NCH];
   logic [DW-1:0]  cnt_q  [NCH];
   logic [DW-1:0]  cnt_d  [NCH];
   logic [DW-1:0]  rd_data_q, rd_mux, pre_rd;
   logic           rd_valid_q;
   logic           tick;
   logic [CW-1:0]  wr_ch, rd_ch;
   logic [3:0]     wr_off, rd_off;
   logic           wr_ch_hit, rd_ch_hit;

   assign wr_ch     = bus.wr_addr[AW-1:4];
   assign wr_off    = bus.wr_addr[3:0];
   assign rd_ch     = bus.rd_addr[AW-1:4];
   assign rd_off    = bus.rd_addr[3:0];
   assign wr_ch_hit = wr_ch < CW'(NCH);
   assign rd_ch_hit = rd_ch < CW'(NCH);

`ifdef TIMER_PRESCALER_EN
   logic [15:0] pre_q, pre_d, pcnt_q, pcnt_d;
   logic        pre_wr;

   assign pre_wr = bus.wr_en && (bus.wr_addr == A_PRE);
   assign tick   = (pcnt_q == pre_q);
   assign pre_rd = {{(DW-16){1'b0}}, pre_q};

   always_comb begin
      pre_d  = pre_q;
      pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      if (pre_wr) begin
         pre_d  = bus.wr_data[15:0];
         pcnt_d = 16'd0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_q  <= '0;
         pcnt_q <= '0;
      end else begin
         pre_q  <= pre_d;
         pcnt_q <= pcnt_d;
      end
   end
`else
   assign tick   = 1'b1;
   assign pre_rd = '0;
`endif

   // Tick processing uses pre-edge state; a CTRL/LOAD write then overrides it.
   always_comb begin
      en_d  = en_q;
      per_d = per_q;
      fire  = '0;
      ien_d = ien_q;
      for (int c = 0; c < NCH; c++) begin
         load_d[c] = load_q[c];
         cnt_d[c]  = cnt_q[c];
         if (tick && en_q[c]) begin
            if (cnt_q[c] == '0) begin
               fire[c] = 1'b1;
               if (per_q[c]) cnt_d[c] = load_q[c];
               else          en_d[c]  = 1'b0;
            end else begin
               cnt_d[c] = cnt_q[c] - DW'(1);
            end
         end
         if (bus.wr_en && wr_ch_hit && (wr_ch == CW'(c))) begin
            if (wr_off == 4'h0) begin
               if (bus.wr_data[0] && !en_q[c]) cnt_d[c] = load_q[c];
               en_d[c]  = bus.wr_data[0];
               per_d[c] = bus.wr_data[1];
            end else if (wr_off == 4'h4) begin
               load_d[c] = bus.wr_data;
            end
         end
      end
      stat_d = stat_q;
      if (bus.wr_en && (bus.wr_addr == A_STAT)) stat_d = stat_q & ~bus.wr_data[NCH-1:0];
      stat_d = stat_d | fire;
      if (bus.wr_en && (bus.wr_addr == A_IEN)) ien_d = bus.wr_data[NCH-1:0];
   end

   always_comb begin
      rd_mux = UNMAPPED;
      if (rd_ch_hit) begin
         for (int c = 0; c < NCH; c++) begin
            if (rd_ch == CW'(c)) begin
               case (rd_off)
                  4'h0:    rd_mux = {{(DW-2){1'b0}}, per_q[c], en_q[c]};
                  4'h4:    rd_mux = load_q[c];
                  4'h8:    rd_mux = cnt_q[c];
                  4'hC:    rd_mux = '0;
                  default: rd_mux = UNMAPPED;
               endcase
            end
         end
      end else begin
         case (bus.rd_addr)
            A_STAT:  rd_mux = {{(DW-NCH){1'b0}}, stat_q};
            A_IEN:   rd_mux = {{(DW-NCH){1'b0}}, ien_q};
            A_PRE:   rd_mux = pre_rd;
            default: rd_mux = UNMAPPED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         en_q       <= '0;
         per_q      <= '0;
         stat_q     <= '0;
         ien_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            load_q[c] <= '0;
            cnt_q[c]  <= '0;
         end
      end else begin
         en_q       <= en_d;
         per_q      <= per_d;
         stat_q     <= stat_d;
         ien_q      <= ien_d;
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_mux;
         for (int c = 0; c < NCH; c++) begin
            load_q[c] <= load_d[c];
            cnt_q[c]  <= cnt_d[c];
         end
      end
   end

   assign bus.wr_ready = 1'b1;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.irq_vec  = stat_q & ien_q;
   assign bus.irq      = |(stat_q & ien_q);
endmodule

// File: tb/tb_multi_timer_regs.sv
// Randomized and directed checks of multi_timer_regs against a register-level reference model.
module tb_multi_timer_regs;
   localparam int NCH = 4;
`ifdef TIMER_PRESCALER_EN
   localparam int PRE_PERIOD = 10;
`else
   localparam int PRE_PERIOD = 2;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   multi_timer_regs_if #(.AW(8), .DW(32), .NCH(NCH)) bus ();
   multi_timer_regs #(.NCH(NCH), .AW(8), .DW(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   bit             m_en  [NCH];
   bit             m_per [NCH];
   logic [31:0]    m_load[NCH];
   logic [31:0]    m_cnt [NCH];
   logic [NCH-1:0] m_stat, m_ien;
   int unsigned    m_pre, m_pcnt;
   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int c = 0; c < NCH; c++) begin
         m_en[c] = 0; m_per[c] = 0; m_load[c] = '0; m_cnt[c] = '0;
      end
      m_stat = '0; m_ien = '0; m_pre = 0; m_pcnt = 0;
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] a);
      int ch, off;
      ch  = int'(a) / 16;
      off = int'(a) % 16;
      if (a == 8'hF0) return 32'(m_stat);
      if (a == 8'hF4) return 32'(m_ien);
`ifdef TIMER_PRESCALER_EN
      if (a == 8'hF8) return m_pre;
`else
      if (a == 8'hF8) return 32'h0;
`endif
      if (ch >= NCH) return 32'hDEADBEEF;
      case (off)
         0:       return {30'h0, m_per[ch], m_en[ch]};
         4:       return m_load[ch];
         8:       return m_cnt[ch];
         12:      return 32'h0;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   // One clock of the register-level behaviour: timers act on the old state, then the write lands.
   function automatic void m_step(input logic [7:0] wa, input logic [31:0] wd, input bit we);
      bit             tick;
      bit             old_en[NCH];
      logic [31:0]    old_load[NCH];
      logic [NCH-1:0] fired;
      int ch, off;
      fired = '0;
`ifdef TIMER_PRESCALER_EN
      tick   = (m_pcnt == m_pre);
      m_pcnt = tick ? 0 : m_pcnt + 1;
`else
      tick = 1;
`endif
      old_en   = m_en;
      old_load = m_load;
      for (int c = 0; c < NCH; c++) begin
         if (tick && old_en[c]) begin
            if (m_cnt[c] == 0) begin
               fired[c] = 1'b1;
               if (m_per[c]) m_cnt[c] = old_load[c];
               else          m_en[c]  = 0;
            end else begin
               m_cnt[c] = m_cnt[c] - 1;
            end
         end
      end
      if (we) begin
         ch  = int'(wa) / 16;
         off = int'(wa) % 16;
         if (wa == 8'hF0) m_stat = m_stat & ~wd[NCH-1:0];
         else if (wa == 8'hF4) m_ien = wd[NCH-1:0];
         else if (wa == 8'hF8) begin
`ifdef TIMER_PRESCALER_EN
            m_pre  = wd[15:0];
            m_pcnt = 0;
`endif
         end else if (ch < NCH && off == 0) begin
            if (wd[0] && !old_en[ch]) m_cnt[ch] = old_load[ch];
            m_en[ch]  = wd[0];
            m_per[ch] = wd[1];
         end else if (ch < NCH && off == 4) begin
            m_load[ch] = wd;
         end
      end
      m_stat = m_stat | fired;
   endfunction

   task automatic cyc(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                      input bit re, input logic [7:0] ra);
      logic [31:0] exp_rd;
      bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
      bus.rd_en = re; bus.rd_addr = ra;
      exp_rd = m_read(ra);
      m_step(wa, wd, we);
      @(posedge clk);
      #1;
      chk("rd_valid", bus.rd_valid, re);
      if (re) chk("rd_data", bus.rd_data, exp_rd);
      chk("irq_vec", bus.irq_vec, m_stat & m_ien);
      chk("irq", bus.irq, |(m_stat & m_ien));
      chk("wr_ready", bus.wr_ready, 1);
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      cyc(1, a, d, 0, 8'h00);
   endtask

   task automatic rd(input logic [7:0] a);
      cyc(0, 8'h00, 32'h0, 1, a);
   endtask

   task automatic idle();
      cyc(0, 8'h00, 32'h0, 0, 8'h00);
   endtask

   logic [7:0] addr_list [16] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h20, 8'h24, 8'h30, 8'h34,
                                  8'h08, 8'h0C, 8'h40, 8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h01};

   initial begin
      int ev[$];
      logic [7:0]  a;
      logic [31:0] d;
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_en = 0; bus.rd_addr = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_irq", bus.irq, 0);
      chk("rst_irq_vec", bus.irq_vec, 0);
      @(negedge clk) rstn = 1'b1;

      rd(8'h00); chk("rst_ctrl0", bus.rd_data, 32'h0);
      rd(8'h08); chk("rst_count0", bus.rd_data, 32'h0);
      rd(8'hF0); chk("rst_stat", bus.rd_data, 32'h0);
      rd(8'h40); chk("unmapped_ch4", bus.rd_data, 32'hDEADBEEF);
      idle();    chk("rd_valid_drop", bus.rd_valid, 0);

      // one-shot on ch0
      wr(8'h04, 32'd3);
      wr(8'h00, 32'h1);
      for (int i = 0; i < 4; i++) begin
         rd(8'h08);
         chk("oneshot_count", bus.rd_data, 32'(3 - i));
      end
      rd(8'h00); chk("oneshot_en_clr", bus.rd_data, 32'h0);
      rd(8'hF0); chk("oneshot_stat0", bus.rd_data[0], 1);
      rd(8'h08); chk("oneshot_count_hold", bus.rd_data, 32'h0);

      // periodic on ch1, W1C and set-wins
      wr(8'hF4, 32'h2);
      wr(8'h14, 32'd2);
      wr(8'h10, 32'h3);
      idle();
      idle();          chk("per_irq_e2", bus.irq, 0);
      idle();          chk("per_irq_e3", bus.irq, 1);
      wr(8'hF0, 32'h2); chk("w1c_clear", bus.irq, 0);
      idle();          chk("per_irq_e5", bus.irq, 0);
      idle();          chk("per_irq_e6", bus.irq, 1);
      wr(8'hF0, 32'h2); chk("w1c_clear2", bus.irq, 0);
      idle();
      wr(8'hF0, 32'h2); chk("set_wins", bus.irq_vec, 32'h2);
      wr(8'h10, 32'h0);

      // prescaled periodic on ch2: measure spacing of set edges
      wr(8'hF8, 32'd4);
      wr(8'hF4, 32'h4);
      wr(8'h24, 32'd1);
      wr(8'h20, 32'h3);
      for (int i = 0; i < 40; i++) begin
         cyc(1, 8'hF0, 32'h4, 0, 8'h00);
         if (bus.irq_vec[2]) ev.push_back(i);
      end
      chk("pre_events", (ev.size() >= 3), 1);
      if (ev.size() >= 3) begin
         chk("pre_period_a", ev[1] - ev[0], PRE_PERIOD);
         chk("pre_period_b", ev[2] - ev[1], PRE_PERIOD);
      end
      wr(8'h20, 32'h0);

      // masked ch3 still latches status
      wr(8'hF8, 32'h0);
      wr(8'hF4, 32'h0);
      wr(8'hF0, 32'hF);
      wr(8'h34, 32'h0);
      wr(8'h30, 32'h1);
      repeat (3) idle();
      rd(8'hF0); chk("masked_stat3", bus.rd_data[3], 1);
      chk("masked_irq", bus.irq, 0);
      wr(8'hF4, 32'h8); chk("unmask_irq", bus.irq, 1);

      // randomized traffic against the model
      for (int i = 0; i < 500; i++) begin
         bit we, re;
         logic [7:0] ra;
         we = ($urandom_range(0, 2) == 0);
         re = ($urandom_range(0, 1) == 0);
         a  = addr_list[$urandom_range(0, 15)];
         if (a == 8'hF0 || a == 8'hF4 || a == 8'hF8 || a[3:0] == 4'h0) d = $urandom_range(0, 15);
         else d = $urandom_range(0, 6);
         ra = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addr_list[$urandom_range(0, 15)];
         cyc(we, a, d, re, ra);
      end

      // asynchronous reset while ch0 counts
      wr(8'hF8, 32'h0);
      wr(8'hF4, 32'hF);
      wr(8'h30, 32'h0);
      wr(8'h34, 32'h0);
      wr(8'h30, 32'h1);
      wr(8'h00, 32'h0);
      wr(8'h04, 32'd100);
      wr(8'h00, 32'h1);
      repeat (3) idle();
      chk("pre_rst_irq", bus.irq, 1);
      rd(8'h04); chk("pre_rst_load", bus.rd_data, 32'd100);
      #1 rstn = 1'b0;
      #1;
      chk("async_rd_valid", bus.rd_valid, 0);
      chk("async_rd_data", bus.rd_data, 0);
      chk("async_irq", bus.irq, 0);
      chk("async_irq_vec", bus.irq_vec, 0);
      m_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      rd(8'h08); chk("post_rst_count", bus.rd_data, 32'h0);
      rd(8'h00); chk("post_rst_ctrl", bus.rd_data, 32'h0);
      repeat (5) idle();
      chk("post_rst_irq", bus.irq, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/multi_timer_regs.md
# multi_timer_regs

Parametrised successor to the single-channel timer register bank: NCH independent 32-bit down-counting timers behind one shared register map, with a shared prescaler, per-channel one-shot/periodic mode, write-1-to-clear interrupt status, interrupt enable mask and a registered read path. It sits between the AXI4-Lite slave front end (wr/rd strobes) and the interrupt controller, and contains the counters themselves.

## Interface
- NCH, 4, number of timer channels (1..15)
- AW, 8, register address width (byte address)
- DW, 32, data width (fixed 32)
- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- wr_addr  in  AW  write byte address
- wr_data  in  DW  write data
- wr_en  in  1  write strobe, one write per cycle
- wr_ready  out  1  tied 1
- rd_addr  in  AW  read byte address
- rd_en  in  1  read strobe
- rd_data  out  DW  read data, registered
- rd_valid  out  1  read data valid, one cycle after rd_en
- irq  out  1  OR of (IRQ_STAT & IRQ_EN)
- irq_vec  out  NCH  per-channel IRQ_STAT & IRQ_EN

## Operation
- Map, channel c at base c*0x10: +0x0 CTRL (bit0 EN, bit1 PERIODIC, rest read 0), +0x4 LOAD, +0x8 COUNT (read-only, writes ignored), +0xC reserved (reads 0).
- Global: 0xF0 IRQ_STAT (W1C, bits NCH-1:0), 0xF4 IRQ_EN (RW), 0xF8 PRESCALE (RW, 16 bits, upper bits read 0).
- Unmapped addresses, including channels >= NCH: write ignored, read 0xDEADBEEF.
- Prescaler: pre_cnt counts 0..PRESCALE; tick asserted on the cycle pre_cnt==PRESCALE, then pre_cnt wraps to 0. Free-running; any PRESCALE write clears pre_cnt to 0.
- CTRL write with EN 0->1: COUNT<=LOAD on the same edge. EN 1->1 rewrite: COUNT unchanged, only PERIODIC updated. EN->0: COUNT holds.
- On tick with EN=1: COUNT!=0 -> COUNT-1. COUNT==0 -> set IRQ_STAT[c]; periodic: COUNT<=LOAD; one-shot: EN<=0, COUNT stays 0.
- LOAD=0: periodic fires on every tick; one-shot fires on the first tick after enable.
- LOAD write while running takes effect at the next reload or enable only.
- IRQ_STAT bit set by hardware and cleared by W1C on the same edge: set wins.
- IRQ_EN masks outputs only; IRQ_STAT bits still latch when masked.

## Timing
- Reset: all CTRL/LOAD/COUNT/IRQ_STAT/IRQ_EN/PRESCALE = 0, pre_cnt = 0, rd_data = 0, rd_valid = 0, irq = 0, irq_vec = 0.
- Writes: register updates on the edge where wr_en=1; visible to reads and outputs from the next cycle.
- Reads: rd_data/rd_valid registered on the edge where rd_en=1; the value is the pre-edge state (a same-cycle write is not visible). rd_valid=0 when rd_en=0; rd_data holds its last value.
- Back-to-back reads every cycle are supported, latency 1 each.
- irq/irq_vec are combinational from registers: assert the cycle after the IRQ_STAT set edge.
- COUNT wraps never; zero detection precedes decrement.
- Reset asserted mid-count: all state clears immediately (asynchronous); no irq after release until re-enabled.

## Configuration
- TIMER_PRESCALER_EN defined: prescaler as described.
- Undefined: tick = 1 every cycle, no pre_cnt logic, PRESCALE writes ignored and read 0.

## Test plan
- Reset then read 0x00, 0x08, 0xF0, 0x40 (NCH=4) -> 0, 0, 0, 0xDEADBEEF, each rd_valid exactly 1 cycle after rd_en.
- PRESCALE=0, ch0 LOAD=3, CTRL=0x1 -> COUNT reads 3,2,1,0 on successive cycles, IRQ_STAT[0]=1, EN self-clears, COUNT stays 0.
- ch1 LOAD=2, CTRL=0x3, IRQ_EN=0x2 -> irq pulses set every 3 ticks; write 0xF0=0x2 clears irq one cycle later; clear on a set cycle leaves bit 1.
- PRESCALE=4, ch2 LOAD=1 periodic -> IRQ_STAT[2] sets every 10 cycles; without TIMER_PRESCALER_EN, every 2 cycles.
- IRQ_EN=0, ch3 fires -> IRQ_STAT[3]=1, irq=0; then IRQ_EN=0x8 -> irq=1 next cycle.
- rstn low while ch0 counts from LOAD=100 -> all outputs 0 asynchronously, COUNT=0 after release.
